reduce_tree: RTL
================

# reduce_tree

Parametrised, pipelined N-input bitwise reduction unit: the sequential successor to the fixed 8-input OR reduction gate. It reduces a WIDTH-bit word to one bit with a selectable operator (OR, AND, XOR, NAND) through a balanced binary tree with one register stage per tree level. A valid/ready handshake with backpressure lets it sit between CPU-side datapath stages, for example as a zero/all-ones/parity flag generator.

## Interface
- WIDTH, default 16: input word width; must be a power of two, at least 2. LEVELS = log2(WIDTH).
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all pipeline state.
- in  in  WIDTH  operand word.
- op  in  2  operator select: 00 OR, 01 AND, 10 XOR, 11 NAND (AND with the final result inverted).
- in_valid  in  1  `in`/`op` present.
- in_ready  out  1  unit can accept this cycle.
- out  out  1  reduction result.
- out_valid  out  1  `out` holds a valid result.
- out_ready  in  1  downstream accepts `out` this cycle.

## Operation
- Tree structure:
  - Level k (k = 1..LEVELS) holds WIDTH/2^k partial bits.
  - Each partial bit is the pairwise combine of adjacent level k-1 bits: bits 2i and 2i+1 produce bit i.
  - Level 0 is `in`.
- Combine function per stage:
  - op 00 uses OR.
  - op 01 and op 11 use AND.
  - op 10 uses XOR.
- NAND inversion is applied once, when the final level is registered; it is not applied at every level.
- `op` is captured with the data and travels down the pipeline alongside each item. Items with different ops may be interleaved back to back.
- Each stage k holds a valid bit v[k], its partial bits and its op. `out` is stage LEVELS's single bit, and out_valid = v[LEVELS].
- stall = out_valid AND NOT out_ready.
- in_ready = NOT stall AND NOT reset. This is combinational.
- Advance rule: when stall is 0, every stage loads from the stage above it.
  - v[1] loads (in_valid AND in_ready).
  - v[k] loads v[k-1].
- When stall is 1, all stages hold, including partial bits, ops and valid bits.
- Bubbles (v=0) advance like data. They do not collapse while stalled; the pipeline is a simple global-stall pipeline.
- Partial-data registers of invalid stages are don't-care, but must be deterministic: they are cleared by reset.
- Reset:
  - All v[k] = 0, all partial bits = 0, all ops = 00.
  - Therefore out = 0 and out_valid = 0 from the first edge with reset high.
  - in_ready = 0 while reset is high and 1 on the first cycle after reset deasserts.
- Reset mid-operation: all in-flight items are discarded with no output. A transfer presented in the same cycle as reset is not accepted.

## Timing
- Latency: an item accepted at edge t appears with out_valid = 1 after edge t+LEVELS-1, i.e. LEVELS cycles of register delay. For WIDTH=8 the latency is 3; for WIDTH=16 it is 4.
- Throughput: one item per cycle when out_ready is held high.
- Handshake:
  - An input transfer occurs on a rising edge where in_valid and in_ready are both 1.
  - An output transfer occurs on a rising edge where out_valid and out_ready are both 1.
- While out_valid = 1 and out_ready = 0, `out` is stable across edges.
- Simultaneous output and input transfer in the same cycle is legal and required; the full pipeline moves one slot.
- out_ready = 1 with out_valid = 0 has no effect.
- in_valid while in_ready = 0: the item is not captured, and the source must hold it.
- WIDTH = 2: LEVELS = 1, giving a single stage of latency 1.

## Test plan
All scenarios use WIDTH=8, latency 3, with out_ready held high unless stated.
- Reset: hold reset 2 cycles with in_valid=1 -> out=0, out_valid=0, in_ready=0 during reset; after release, in_ready=1 and no spurious out_valid for 3 cycles.
- OR and AND: feed 8'h00/OR, 8'h10/OR, 8'hFF/AND, 8'hFE/AND back to back -> out_valid for 4 consecutive cycles starting 3 cycles after the first accept, with out = 0, 1, 1, 0.
- XOR and NAND interleaved: feed 8'h07/XOR, 8'h03/XOR, 8'hFF/NAND, 8'h7F/NAND -> out = 1, 0, 0, 1 in order.
- Backpressure: stream 8'h01, 8'h00, 8'h80 with OR and drop out_ready for 4 cycles while the first result is valid -> out stays 1, in_ready=0 during the stall, then results 1, 0, 1 are delivered with none lost or duplicated.
- Reset mid-flight: accept 2 items, assert reset one cycle later -> out_valid never rises for either item; a new item 8'hFF/AND accepted after reset gives out=1 exactly 3 cycles later.
- Parametric sweep: WIDTH=2 and WIDTH=32 against a reference model on random in/op and random out_ready toggling -> every accepted item emerges exactly once, in order, with the correct value and latency LEVELS when unstalled.

Source files
------------

// File: rtl/reduce_tree.sv
// Pipelined WIDTH-input bitwise reduction (OR/AND/XOR/NAND) with one register stage per
// tree level and a global-stall valid/ready handshake.
module reduce_tree #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned NODES  = 2 * WIDTH - 1;

  function automatic logic combine(input logic a, input logic b, input logic [1:0] o,
                                   input logic last);
    logic r;
    case (o)
      2'b00:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = a & b;
    endcase
    // NAND inverts only once, on the way into the final level
    if (last && (o == 2'b11)) r = ~r;
    return r;
  endfunction

  // node holds every tree level back to back: level 0 (the input) in the low WIDTH bits,
  // level k registered bits above it, the final result in the top bit.
  logic [NODES-1:0]            node;
  logic [WIDTH-2:0]            data_q;
  logic [WIDTH-2:0]            data_d;
  logic [LEVELS:1]             v_q;
  logic [LEVELS-1:0][1:0]      stage_op;
  logic                        stall;
  logic                        accept;

  assign node      = {data_q, in};
  assign stall     = v_q[LEVELS] & ~out_ready;
  assign in_ready  = ~stall & ~reset;
  assign accept    = in_valid & in_ready;
  assign out       = node[NODES-1];
  assign out_valid = v_q[LEVELS];

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int unsigned PO = 2 * WIDTH - ((2 * WIDTH) >> (k - 1));
    localparam int unsigned CO = 2 * WIDTH - ((2 * WIDTH) >> k);
    for (genvar i = 0; i < (WIDTH >> k); i++) begin : g_node
      assign data_d[CO - WIDTH + i] = combine(node[PO + 2 * i], node[PO + 2 * i + 1],
                                              stage_op[k - 1], (k == LEVELS));
    end
  end

  // The op of the final stage is never needed after inversion, so only LEVELS-1 op
  // registers exist; stage_op[k-1] is the op that level k is computed with.
  if (LEVELS > 1) begin : g_op
    logic [LEVELS-2:0][1:0] op_q;

    assign stage_op = {op_q, op};

    always_ff @(posedge clock) begin
      if (reset) begin
        op_q <= '0;
      end else if (!stall) begin
        op_q <= stage_op[LEVELS-2:0];
      end
    end
  end else begin : g_no_op
    assign stage_op = op;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
      v_q    <= '0;
    end else if (!stall) begin
      data_q <= data_d;
      v_q[1] <= accept;
      for (int k = 2; k <= LEVELS; k++) begin
        v_q[k] <= v_q[k-1];
      end
    end
  end

endmodule
